// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel divider, x/y raster counters,
// registered sync/active decode, line/frame strobes and a completed-frame counter.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int XW        = 10,
  parameter int YW        = 10,
  parameter int FRAME_W   = 16,
  parameter int CE_DIV    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  output logic               pix_ce,
  output logic               hsync,
  output logic               vsync,
  output logic               activevideo,
  output logic [XW-1:0]      x_px,
  output logic [YW-1:0]      y_px,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] X_ACT  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_BEG = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] Y_ACT  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_BEG = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END = YW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [3:0]    DIV_LAST = 4'(CE_DIV - 1);

  function automatic logic hs_level(input logic [XW-1:0] x);
    return ((x >= HS_BEG) && (x < HS_END)) ? HSYNC_POL : !HSYNC_POL;
  endfunction

  function automatic logic vs_level(input logic [YW-1:0] y);
    return ((y >= VS_BEG) && (y < VS_END)) ? VSYNC_POL : !VSYNC_POL;
  endfunction

  logic               run_q;
  logic [3:0]         div_q, div_d;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               hs_q, hs_d;
  logic               vs_q, vs_d;
  logic               av_q, av_d;
  logic               ls_q, ls_d;
  logic               fs_q, fs_d;
  logic               x_wrap, y_wrap;

  // run_q holds the divider and raster still until the first edge after reset,
  // so pix_ce is low throughout reset without a combinational path from rst.
  assign pix_ce = ena && run_q && (div_q == DIV_LAST);

  always_comb begin
    div_d   = div_q;
    x_d     = x_q;
    y_d     = y_q;
    frame_d = frame_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    av_d    = av_q;
    ls_d    = 1'b0;
    fs_d    = 1'b0;
    x_wrap  = (x_q == X_LAST);
    y_wrap  = (y_q == Y_LAST);

    if (ena && run_q) begin
      div_d = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
    end

    if (pix_ce) begin
      x_d = x_wrap ? '0 : x_q + XW'(1);
      if (x_wrap) begin
        y_d  = y_wrap ? '0 : y_q + YW'(1);
        ls_d = 1'b1;
        if (y_wrap) begin
          fs_d    = 1'b1;
          frame_d = frame_q + FRAME_W'(1);
        end
      end
      // Decode from the next position so levels line up with the counters shown.
      hs_d = hs_level(x_d);
      vs_d = vs_level(y_d);
      av_d = (x_d < X_ACT) && (y_d < Y_ACT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q   <= 1'b0;
      div_q   <= 4'd0;
      x_q     <= '0;
      y_q     <= '0;
      frame_q <= '0;
      hs_q    <= !HSYNC_POL;
      vs_q    <= !VSYNC_POL;
      av_q    <= 1'b1;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      run_q   <= 1'b1;
      div_q   <= div_d;
      x_q     <= x_d;
      y_q     <= y_d;
      frame_q <= frame_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      av_q    <= av_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign activevideo = av_q;
  assign x_px        = x_q;
  assign y_px        = y_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign frame_cnt   = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a 14x8 raster: CE_DIV=1, CE_DIV=3 and
// inverted-polarity instances share clk/rst/ena.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst;
  logic ena;

  logic       pce1, hs1, vs1, av1, ls1, fs1;
  logic [3:0] x1;
  logic [2:0] y1, f1;
  logic       pce3, hs3, vs3, av3, ls3, fs3;
  logic [3:0] x3;
  logic [2:0] y3, f3;
  logic       pcep, hsp, vsp, avp, lsp, fsp;
  logic [3:0] xp;
  logic [2:0] yp, fp;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                   .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
                   .XW(4), .YW(3), .FRAME_W(3), .CE_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .ena(ena), .pix_ce(pce1), .hsync(hs1), .vsync(vs1),
    .activevideo(av1), .x_px(x1), .y_px(y1), .line_start(ls1),
    .frame_start(fs1), .frame_cnt(f1));

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                   .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
                   .XW(4), .YW(3), .FRAME_W(3), .CE_DIV(3)) dut3 (
    .clk(clk), .rst(rst), .ena(ena), .pix_ce(pce3), .hsync(hs3), .vsync(vs3),
    .activevideo(av3), .x_px(x3), .y_px(y3), .line_start(ls3),
    .frame_start(fs3), .frame_cnt(f3));

  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                   .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
                   .XW(4), .YW(3), .FRAME_W(3), .CE_DIV(1)) dutp (
    .clk(clk), .rst(rst), .ena(ena), .pix_ce(pcep), .hsync(hsp), .vsync(vsp),
    .activevideo(avp), .x_px(xp), .y_px(yp), .line_start(lsp),
    .frame_start(fsp), .frame_cnt(fp));

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Ends sampling cycle c=0: the first negedge after the first rising edge with rst low.
  task automatic start();
    rst = 1'b1;
    ena = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ena = 1'b1;
    repeat (2) tick();
    total++;
    if ({x1, y1, hs1, vs1, av1, ls1, fs1, pce1, f1} !== {4'd0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0}) begin
      bad++;
      $display("FAIL reset_state1 got x=%0d y=%0d hs=%b vs=%b av=%b ls=%b fs=%b pce=%b f=%0d want 0 0 1 1 1 0 0 0 0",
               x1, y1, hs1, vs1, av1, ls1, fs1, pce1, f1);
    end
    total++;
    if ({hsp, vsp, pce3, x3} !== {1'b0, 1'b0, 1'b0, 4'd0}) begin
      bad++;
      $display("FAIL reset_state_pol got hsp=%b vsp=%b pce3=%b x3=%0d want 0 0 0 0", hsp, vsp, pce3, x3);
    end
    rst = 1'b0;
    tick();
    total++;
    if ({x1, ls1, fs1, pce1} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_release got x=%0d ls=%b fs=%b pce=%b want 0 0 0 1", x1, ls1, fs1, pce1);
    end
  endtask

  task automatic test_raster();
    int ex, ey, ef, hlow, vlow, lcnt, fcnt;
    logic e_hs, e_vs, e_av, e_ls, e_fs;
    hlow = 0; vlow = 0; lcnt = 0; fcnt = 0;
    start();
    for (int c = 0; c <= 224; c++) begin
      if (c > 0) tick();
      ex = c % 14;
      ey = (c / 14) % 8;
      ef = (c / 112) % 8;
      e_hs = !(ex >= 10 && ex <= 12);
      e_vs = !(ey >= 5 && ey <= 6);
      e_av = (ex < 8) && (ey < 4);
      e_ls = (c > 0) && (c % 14 == 0);
      e_fs = (c > 0) && (c % 112 == 0);
      total++;
      if ({x1, y1, hs1, vs1, av1, ls1, fs1, pce1, f1} !== {4'(ex), 3'(ey), e_hs, e_vs, e_av, e_ls, e_fs, 1'b1, 3'(ef)}) begin
        bad++;
        $display("FAIL raster c=%0d got x=%0d y=%0d hs=%b vs=%b av=%b ls=%b fs=%b pce=%b f=%0d want %0d %0d %b %b %b %b %b 1 %0d",
                 c, x1, y1, hs1, vs1, av1, ls1, fs1, pce1, f1, ex, ey, e_hs, e_vs, e_av, e_ls, e_fs, ef);
      end
      total++;
      if ({hsp, vsp} !== {!e_hs, !e_vs}) begin
        bad++;
        $display("FAIL raster_pol c=%0d got hs=%b vs=%b want %b %b", c, hsp, vsp, !e_hs, !e_vs);
      end
      if (c < 112 && !vs1) vlow++;
      if (c < 14 && !hs1) hlow++;
      if (ls1) lcnt++;
      if (fs1) fcnt++;
    end
    total++;
    if (vlow !== 28) begin
      bad++;
      $display("FAIL vsync_width got %0d want 28", vlow);
    end
    total++;
    if (hlow !== 3) begin
      bad++;
      $display("FAIL hsync_width got %0d want 3", hlow);
    end
    total++;
    if ({lcnt, fcnt} !== {32'd16, 32'd2}) begin
      bad++;
      $display("FAIL strobe_counts got ls=%0d fs=%0d want 16 2", lcnt, fcnt);
    end
  endtask

  task automatic test_frame_cnt();
    int ef, fcnt;
    logic e_fs;
    fcnt = 0;
    start();
    for (int c = 0; c <= 9 * 112 + 14; c++) begin
      if (c > 0) tick();
      ef = (c / 112) % 8;
      e_fs = (c > 0) && (c % 112 == 0);
      total++;
      if ({f1, fs1} !== {3'(ef), e_fs}) begin
        bad++;
        $display("FAIL frame_cnt c=%0d got f=%0d fs=%b want %0d %b", c, f1, fs1, ef, e_fs);
      end
      if (fs1) fcnt++;
    end
    total++;
    if (fcnt !== 9) begin
      bad++;
      $display("FAIL frame_pulses got %0d want 9", fcnt);
    end
  endtask

  task automatic test_ce_div();
    int p, ex, ey, wide;
    logic e_pce, e_ls, e_hs, e_av, prev_ls;
    wide = 0; prev_ls = 1'b0;
    start();
    for (int c = 0; c <= 90; c++) begin
      if (c > 0) tick();
      p = c / 3;
      ex = p % 14;
      ey = (p / 14) % 8;
      e_pce = (c % 3 == 2);
      e_ls = (c > 0) && (c % 42 == 0);
      e_hs = !(ex >= 10 && ex <= 12);
      e_av = (ex < 8) && (ey < 4);
      total++;
      if ({x3, y3, pce3, ls3, hs3, av3} !== {4'(ex), 3'(ey), e_pce, e_ls, e_hs, e_av}) begin
        bad++;
        $display("FAIL ce_div c=%0d got x=%0d y=%0d pce=%b ls=%b hs=%b av=%b want %0d %0d %b %b %b %b",
                 c, x3, y3, pce3, ls3, hs3, av3, ex, ey, e_pce, e_ls, e_hs, e_av);
      end
      if (ls3 && prev_ls) wide++;
      prev_ls = ls3;
    end
    total++;
    if (wide !== 0) begin
      bad++;
      $display("FAIL ce_div_strobe_width got %0d wide cycles want 0", wide);
    end
  endtask

  task automatic test_freeze();
    start();
    for (int c = 1; c <= 33; c++) tick();
    total++;
    if ({x1, y1} !== {4'd5, 3'd2}) begin
      bad++;
      $display("FAIL freeze_pos got x=%0d y=%0d want 5 2", x1, y1);
    end
    ena = 1'b0;
    #1;
    total++;
    if ({pce1, pce3} !== 2'b00) begin
      bad++;
      $display("FAIL freeze_pce got %b%b want 00", pce1, pce3);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if ({x1, y1, hs1, vs1, av1, ls1, fs1, pce1, f1} !== {4'd5, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0}) begin
        bad++;
        $display("FAIL freeze_hold i=%0d got x=%0d y=%0d hs=%b vs=%b av=%b ls=%b fs=%b pce=%b f=%0d want 5 2 1 1 1 0 0 0 0",
                 i, x1, y1, hs1, vs1, av1, ls1, fs1, pce1, f1);
      end
    end
    ena = 1'b1;
    #1;
    total++;
    if (pce1 !== 1'b1) begin
      bad++;
      $display("FAIL resume_pce got %b want 1", pce1);
    end
    tick();
    total++;
    if ({x1, y1, ls1} !== {4'd6, 3'd2, 1'b0}) begin
      bad++;
      $display("FAIL resume_x6 got x=%0d y=%0d ls=%b want 6 2 0", x1, y1, ls1);
    end
    tick();
    total++;
    if (x1 !== 4'd7) begin
      bad++;
      $display("FAIL resume_x7 got x=%0d want 7", x1);
    end
  endtask

  task automatic test_async_reset();
    start();
    for (int c = 1; c <= 207; c++) tick();
    total++;
    if ({x1, y1, hs1, vs1, hsp, vsp, f1} !== {4'd11, 3'd6, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1}) begin
      bad++;
      $display("FAIL pre_reset got x=%0d y=%0d hs=%b vs=%b hsp=%b vsp=%b f=%0d want 11 6 0 0 1 1 1",
               x1, y1, hs1, vs1, hsp, vsp, f1);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({x1, y1, hs1, vs1, av1, ls1, fs1, pce1, f1} !== {4'd0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0}) begin
      bad++;
      $display("FAIL async_reset got x=%0d y=%0d hs=%b vs=%b av=%b ls=%b fs=%b pce=%b f=%0d want 0 0 1 1 1 0 0 0 0",
               x1, y1, hs1, vs1, av1, ls1, fs1, pce1, f1);
    end
    total++;
    if ({hsp, vsp, x3, pce3} !== {1'b0, 1'b0, 4'd0, 1'b0}) begin
      bad++;
      $display("FAIL async_reset_pol got hsp=%b vsp=%b x3=%0d pce3=%b want 0 0 0 0", hsp, vsp, x3, pce3);
    end
    tick();
    rst = 1'b0;
    tick();
    total++;
    if ({x1, ls1, fs1, pce1, pce3} !== {4'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL post_reset got x=%0d ls=%b fs=%b pce=%b pce3=%b want 0 0 0 1 0", x1, ls1, fs1, pce1, pce3);
    end
    repeat (2) tick();
    total++;
    if ({x1, x3, pce3} !== {4'd2, 4'd0, 1'b1}) begin
      bad++;
      $display("FAIL post_reset_div got x1=%0d x3=%0d pce3=%b want 2 0 1", x1, x3, pce3);
    end
  endtask

  initial begin
    rst = 1'b1;
    ena = 1'b1;
    test_reset();
    test_raster();
    test_frame_cnt();
    test_ce_div();
    test_freeze();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
